// File: rtl/feature_bank_router_pkg.sv
// Shared defaults, fill-state encoding and bank-index helper for feature_bank_router.
package feature_bank_router_pkg;

   localparam int NUM_BANKS_DEF     = 2;
   localparam int ADDR_WIDTH_DEF    = 15;
   localparam int FEATURE_WIDTH_DEF = 16;

   typedef enum logic {
      FILL = 1'b0,
      WAIT = 1'b1
   } fill_state_e;

   // Round-robin successor of a bank index, wrapping at num_banks-1.
   function automatic int next_bank_idx(input int cur, input int num_banks);
      return (cur >= num_banks - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/feature_bank_router_if.sv
// Fetcher-side feature write stream: valid/ready handshake plus bank select, address and data.
interface feature_bank_router_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_W      = 1
);
   logic                  fetcher_to_mem;
   logic                  fetcher_ready;
   logic [SEL_W-1:0]      wr_feature_sel;
   logic [ADDR_WIDTH-1:0] wr_feature_addr;
   logic [DATA_WIDTH-1:0] wr_feature_data;

   modport master (
      output fetcher_to_mem, wr_feature_sel, wr_feature_addr, wr_feature_data,
      input  fetcher_ready
   );

   modport slave (
      input  fetcher_to_mem, wr_feature_sel, wr_feature_addr, wr_feature_data,
      output fetcher_ready
   );
endinterface

// File: rtl/feature_bank_router_bank_full_tracker.sv
// Per-bank full flags with set-over-release priority, plus the successor bank and whether it
// will be free once this cycle's set/releases land.
module feature_bank_router_bank_full_tracker
   import feature_bank_router_pkg::*;
#(
   parameter int NUM_BANKS = 2,
   parameter int SEL_W     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [SEL_W-1:0]     set_idx,
   input  logic [NUM_BANKS-1:0] bank_release,
   input  logic [SEL_W-1:0]     cur_bank,
   output logic [NUM_BANKS-1:0] bank_full,
   output logic [SEL_W-1:0]     next_bank,
   output logic                 next_bank_free
);
   logic [NUM_BANKS-1:0] full_q;
   logic [NUM_BANKS-1:0] full_d;

   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         assign full_d[gi] = (set_en && set_idx == SEL_W'(gi)) || (full_q[gi] && !bank_release[gi]);
      end
   endgenerate

   assign next_bank      = SEL_W'(next_bank_idx(int'(cur_bank), NUM_BANKS));
   assign next_bank_free = !full_d[next_bank];
   assign bank_full      = full_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= '0;
      end else begin
         full_q <= full_d;
      end
   end
endmodule

// File: rtl/feature_bank_router.sv
// Routes the fetcher feature write stream into NUM_BANKS buffers, manual select or auto fill.
// Define FEATURE_LOAD_ADDR_GEN_EN to generate the per-tile write address internally.
module feature_bank_router
   import feature_bank_router_pkg::*;
#(
   parameter int NUM_BANKS     = NUM_BANKS_DEF,
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
   parameter int DATA_WIDTH    = 2 * FEATURE_WIDTH,
   parameter int SEL_W         = $clog2(NUM_BANKS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cfg_auto,
   input  logic [ADDR_WIDTH:0]             cfg_tile_len,
   feature_bank_router_if.slave            wr,
   output logic [NUM_BANKS-1:0]            mem_wr_en,
   output logic [NUM_BANKS*ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wr_data,
   output logic [NUM_BANKS-1:0]            bank_full,
   input  logic [NUM_BANKS-1:0]            bank_release,
   output logic [SEL_W-1:0]                cur_bank,
   output logic                            sel_err
);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

   fill_state_e                   state_q, state_d;
   logic [SEL_W-1:0]              cur_q, cur_d;
   logic [ADDR_WIDTH:0]           count_q, count_d, count_base, tile_m1;
   logic                          auto_q;
   logic                          sel_err_q, sel_err_d;
   logic [NUM_BANKS-1:0]          en_q, en_d;
   logic [NUM_BANKS*ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [NUM_BANKS*DATA_WIDTH-1:0] data_q, data_d;

   logic                          ready, accept, mode_sw, tgt_valid, set_en, next_free;
   logic [SEL_W-1:0]              tgt_bank, next_bank;
   logic [ADDR_WIDTH-1:0]         wr_addr;

   assign ready   = !cfg_auto || state_q == FILL;
   assign accept  = wr.fetcher_to_mem && ready;
   assign mode_sw = cfg_auto != auto_q;
   // A mode change restarts the tile count before this cycle's word is counted.
   assign count_base = mode_sw ? '0 : count_q;
   assign tile_m1    = (cfg_tile_len == '0) ? '0 : cfg_tile_len - CNT_ONE;

   assign wr.fetcher_ready = ready;
   assign tgt_bank  = cfg_auto ? cur_q : wr.wr_feature_sel;
   assign tgt_valid = accept && (cfg_auto || ({1'b0, wr.wr_feature_sel} < (SEL_W+1)'(NUM_BANKS)));

`ifdef FEATURE_LOAD_ADDR_GEN_EN
   assign wr_addr = count_base[ADDR_WIDTH-1:0];
`else
   assign wr_addr = wr.wr_feature_addr;
`endif

   feature_bank_router_bank_full_tracker #(
      .NUM_BANKS (NUM_BANKS),
      .SEL_W     (SEL_W)
   ) u_tracker (
      .clk            (clk),
      .rst            (rst),
      .set_en         (set_en),
      .set_idx        (cur_q),
      .bank_release   (bank_release),
      .cur_bank       (cur_q),
      .bank_full      (bank_full),
      .next_bank      (next_bank),
      .next_bank_free (next_free)
   );

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      count_d   = count_base;
      sel_err_d = sel_err_q;
      set_en    = 1'b0;
      if (!cfg_auto) begin
         state_d = FILL;
         if (accept) begin
            if (!tgt_valid) sel_err_d = 1'b1;
`ifdef FEATURE_LOAD_ADDR_GEN_EN
            count_d = {1'b0, count_base[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1)};
`endif
         end
      end else if (accept) begin
         if (count_base == tile_m1) begin
            set_en  = 1'b1;
            count_d = '0;
            cur_d   = next_bank;
            state_d = next_free ? FILL : WAIT;
         end else begin
            count_d = count_base + CNT_ONE;
         end
      end else if (mode_sw || state_q == WAIT) begin
         state_d = bank_full[cur_q] ? WAIT : FILL;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_lane
         assign en_d[gi] = tgt_valid && tgt_bank == SEL_W'(gi);
         assign addr_d[gi*ADDR_WIDTH +: ADDR_WIDTH] = en_d[gi] ? wr_addr : '0;
         assign data_d[gi*DATA_WIDTH +: DATA_WIDTH] = en_d[gi] ? wr.wr_feature_data : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FILL;
         cur_q     <= '0;
         count_q   <= '0;
         auto_q    <= 1'b0;
         sel_err_q <= 1'b0;
         en_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         count_q   <= count_d;
         auto_q    <= cfg_auto;
         sel_err_q <= sel_err_d;
         en_q      <= en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign mem_wr_en   = en_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;
   assign cur_bank    = cur_q;
   assign sel_err     = sel_err_q;
endmodule

// File: tb/tb_feature_bank_router.sv
// Bench for feature_bank_router: directed cases plus randomized phases against a tile-level model.
module tb_feature_bank_router;
   localparam int N  = 2;
   localparam int AW = 15;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          drv_auto, drv_valid;
   logic [0:0]    drv_sel;
   logic [AW:0]   drv_tile;
   logic [AW-1:0] drv_addr;
   logic [DW-1:0] drv_data;
   logic [N-1:0]  drv_rel;

   logic [N-1:0]    mem_wr_en, bank_full;
   logic [N*AW-1:0] mem_wr_addr;
   logic [N*DW-1:0] mem_wr_data;
   logic [0:0]      cur_bank;
   logic            sel_err;

   feature_bank_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_W(1)) if2 ();
   assign if2.fetcher_to_mem  = drv_valid;
   assign if2.wr_feature_sel  = drv_sel;
   assign if2.wr_feature_addr = drv_addr;
   assign if2.wr_feature_data = drv_data;

   feature_bank_router #(.NUM_BANKS(N), .ADDR_WIDTH(AW), .FEATURE_WIDTH(16)) dut (
      .clk (clk), .rst (rst), .cfg_auto (drv_auto), .cfg_tile_len (drv_tile), .wr (if2),
      .mem_wr_en (mem_wr_en), .mem_wr_addr (mem_wr_addr), .mem_wr_data (mem_wr_data),
      .bank_full (bank_full), .bank_release (drv_rel), .cur_bank (cur_bank), .sel_err (sel_err)
   );

   // Three-bank instance, used only to reach an out-of-range manual select.
   feature_bank_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_W(2)) if3 ();
   logic [2:0]      en3, full3;
   logic [3*AW-1:0] addr3;
   logic [3*DW-1:0] data3;
   logic [1:0]      cur3;
   logic            err3;

   feature_bank_router #(.NUM_BANKS(3), .ADDR_WIDTH(AW), .FEATURE_WIDTH(16)) dut3 (
      .clk (clk), .rst (rst), .cfg_auto (1'b0), .cfg_tile_len ('0), .wr (if3),
      .mem_wr_en (en3), .mem_wr_addr (addr3), .mem_wr_data (data3),
      .bank_full (full3), .bank_release (3'b000), .cur_bank (cur3), .sel_err (err3)
   );

   // Reference model state
   logic [N-1:0]    m_full;
   int              m_cur, m_count;
   bit              m_wait, m_auto_prev, m_sel_err;
   logic [N-1:0]    exp_en;
   logic [N*AW-1:0] exp_addr;
   logic [N*DW-1:0] exp_data;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_full = '0; m_cur = 0; m_count = 0; m_wait = 0; m_auto_prev = 0; m_sel_err = 0;
      exp_en = '0; exp_addr = '0; exp_data = '0;
   endtask

   // Applies one clock of the router's rules to the inputs currently driven.
   task automatic model_step();
      bit ready, acc, sw;
      int bank, tile;
      logic [N-1:0] nf;
      ready = !drv_auto || !m_wait;
      acc   = drv_valid && ready;
      sw    = drv_auto != m_auto_prev;
      if (sw) m_count = 0;
      bank = drv_auto ? m_cur : int'(drv_sel);
      exp_en = '0; exp_addr = '0; exp_data = '0;
      if (acc && bank < N) begin
         exp_en[bank] = 1'b1;
`ifdef FEATURE_LOAD_ADDR_GEN_EN
         exp_addr[bank*AW +: AW] = AW'(m_count);
`else
         exp_addr[bank*AW +: AW] = drv_addr;
`endif
         exp_data[bank*DW +: DW] = drv_data;
      end
      nf = m_full & ~drv_rel;
      if (!drv_auto) begin
         m_wait = 0;
         if (acc) begin
            if (bank >= N) m_sel_err = 1;
`ifdef FEATURE_LOAD_ADDR_GEN_EN
            m_count = (m_count + 1) % (1 << AW);
`endif
         end
      end else if (acc) begin
         tile = (drv_tile == 0) ? 1 : int'(drv_tile);
         if (m_count == tile - 1) begin
            nf[m_cur] = 1'b1;
            m_count   = 0;
            m_cur     = (m_cur + 1) % N;
            m_wait    = nf[m_cur];
         end else begin
            m_count++;
         end
      end else if (sw || m_wait) begin
         m_wait = m_full[m_cur];
      end
      m_full      = nf;
      m_auto_prev = drv_auto;
   endtask

   task automatic check_outputs();
      check_value("mem_wr_en", 64'(mem_wr_en), 64'(exp_en));
      check_value("mem_wr_addr", 64'(mem_wr_addr), 64'(exp_addr));
      check_value("mem_wr_data", 64'(mem_wr_data), 64'(exp_data));
      check_value("bank_full", 64'(bank_full), 64'(m_full));
      check_value("cur_bank", 64'(cur_bank), 64'(m_cur));
      check_value("fetcher_ready", 64'(if2.fetcher_ready), 64'(!drv_auto || !m_wait));
      check_value("sel_err", 64'(sel_err), 64'(m_sel_err));
      if (mem_wr_en != '0)
         $display("wr en=%b addr=%h data=%h full=%b cur=%0d", mem_wr_en, mem_wr_addr,
                  mem_wr_data, bank_full, cur_bank);
   endtask

   task automatic run_cycle();
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drv_valid = 1'b0;
      drv_rel = '0;
      if3.fetcher_to_mem = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      drv_auto = 1'b0; drv_valid = 1'b0; drv_sel = '0; drv_tile = '0;
      drv_addr = '0; drv_data = '0; drv_rel = '0;
      if3.fetcher_to_mem = 1'b0; if3.wr_feature_sel = '0;
      if3.wr_feature_addr = '0; if3.wr_feature_data = '0;
      #2;
      do_reset();

      // Out-of-range manual select on the three-bank instance
      if3.fetcher_to_mem = 1'b1; if3.wr_feature_sel = 2'd3;
      if3.wr_feature_addr = AW'(9); if3.wr_feature_data = 32'h1111;
      run_cycle();
      check_value("n3_drop_en", 64'(en3), 64'(0));
      check_value("n3_sel_err", 64'(err3), 64'(1));
      check_value("n3_ready", 64'(if3.fetcher_ready), 64'(1));
      if3.wr_feature_sel = 2'd0;
      run_cycle();
      check_value("n3_bank0_en", 64'(en3), 64'(3'b001));
      check_value("n3_sel_err_sticky", 64'(err3), 64'(1));
      if3.wr_feature_sel = 2'd2;
      run_cycle();
      check_value("n3_bank2_en", 64'(en3), 64'(3'b100));
      check_value("n3_sel_err_sticky2", 64'(err3), 64'(1));
      if3.fetcher_to_mem = 1'b0;
      $display("three-bank select-range sequence done");

      // Manual select of bank 1
      drv_sel = 1'b1; drv_valid = 1'b1; drv_addr = AW'(5); drv_data = 32'hBEEF;
      run_cycle();
      check_value("man_en", 64'(mem_wr_en), 64'(2'b10));
      check_value("man_lane1_data", 64'(mem_wr_data[DW +: DW]), 64'(32'hBEEF));
`ifndef FEATURE_LOAD_ADDR_GEN_EN
      check_value("man_lane1_addr", 64'(mem_wr_addr[AW +: AW]), 64'(5));
`endif
      check_value("man_lane0_zero", 64'({mem_wr_addr[0 +: AW], mem_wr_data[0 +: DW]}), 64'(0));

      // Reset while bank 0 is being written
      drv_sel = 1'b0; drv_data = 32'h5A5A;
      run_cycle();
      check_value("rst_pre_en", 64'(mem_wr_en), 64'(2'b01));
      rst = 1'b0;
      #1;
      check_value("rst_en", 64'(mem_wr_en), 64'(0));
      check_value("rst_addr_data", 64'(mem_wr_addr) | 64'(mem_wr_data), 64'(0));
      check_value("rst_ready", 64'(if2.fetcher_ready), 64'(1));
      check_value("rst_cur", 64'(cur_bank), 64'(0));
      do_reset();

      // Auto fill, tile of 4, eight back-to-back words
      drv_auto = 1'b1; drv_tile = (AW+1)'(4);
      run_cycle();
      for (int i = 0; i < 8; i++) begin
         drv_valid = 1'b1; drv_addr = AW'(16 + i); drv_data = DW'(32'hA000 + i);
         run_cycle();
         check_value("auto_bank", 64'(mem_wr_en), (i < 4) ? 64'(2'b01) : 64'(2'b10));
         check_value("auto_full", 64'(bank_full), (i < 3) ? 64'(0) : (i < 7) ? 64'(1) : 64'(3));
      end
      drv_valid = 1'b0;
      check_value("auto_stall_ready", 64'(if2.fetcher_ready), 64'(0));
      check_value("auto_cur_wrap", 64'(cur_bank), 64'(0));
      drv_rel = 2'b01;
      run_cycle();
      drv_rel = 2'b00;
      check_value("rel_full", 64'(bank_full), 64'(2'b10));
      check_value("rel_ready_still0", 64'(if2.fetcher_ready), 64'(0));
      run_cycle();
      check_value("rel_ready", 64'(if2.fetcher_ready), 64'(1));
      drv_valid = 1'b1; drv_data = 32'hC0DE;
      run_cycle();
      drv_valid = 1'b0;
      check_value("rel_next_bank0", 64'(mem_wr_en), 64'(2'b01));

`ifdef FEATURE_LOAD_ADDR_GEN_EN
      do_reset();
      drv_auto = 1'b1; drv_tile = (AW+1)'(3); drv_addr = AW'(15'h7FFF);
      run_cycle();
      for (int i = 0; i < 6; i++) begin
         int lane;
         lane = (i < 3) ? 0 : 1;
         drv_valid = 1'b1; drv_data = DW'(i);
         run_cycle();
         check_value("addr_gen", 64'(mem_wr_addr[lane*AW +: AW]), 64'(i % 3));
      end
      drv_valid = 1'b0;
`endif

      // Randomized phases
      do_reset();
      for (int p = 0; p < 16; p++) begin
         drv_valid = 1'b0; drv_rel = '0;
         drv_auto = 1'($urandom_range(0, 1));
         drv_tile = (AW+1)'($urandom_range(0, 5));
         run_cycle();
         run_cycle();
         $display("phase %0d auto=%0b tile_len=%0d", p, drv_auto, drv_tile);
         for (int c = 0; c < 40; c++) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_sel   = 1'($urandom_range(0, 1));
            drv_addr  = AW'($urandom);
            drv_data  = $urandom;
            drv_rel   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            run_cycle();
         end
      end
      drv_valid = 1'b0; drv_rel = '0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
